// File: rtl/csr_cmd_ctrl.sv
// CSR command sequencer: parses SPI command/data bytes and shares the single CSR RAM port
// with the internal reload requester by round-robin. Optional: CSR_WR_PROTECT_EN.
module csr_cmd_ctrl #(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] spi_data_in,
    input  logic                  spi_data_rdy,
    output logic [DATA_WIDTH-1:0] spi_data_out,
    output logic                  spi_data_latch,
    input  logic                  int_req,
    input  logic                  int_we,
    input  logic [ADDR_WIDTH-1:0] int_addr,
    input  logic [DATA_WIDTH-1:0] int_wdata,
    output logic                  int_gnt,
    output logic [DATA_WIDTH-1:0] int_rdata,
    output logic                  int_rvalid,
    output logic                  csr_we,
    output logic                  csr_re,
    output logic [ADDR_WIDTH-1:0] csr_addr,
    output logic [DATA_WIDTH-1:0] csr_wdata,
    input  logic [DATA_WIDTH-1:0] csr_rdata,
    output logic                  busy,
    output logic [2:0]            err,
    input  logic                  err_clr
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, WAIT_DATA, RD_REQ, RD_DATA, WR_REQ} state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  bad_addr_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  rr_q;         // 0: SPI wins a tie, 1: internal wins a tie
    logic                  int_rd_p1_q;  // internal read granted last cycle, data arrives now

    logic [1:0]            cmd_op;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic                  cmd_bad_addr;
    logic                  spi_req, int_req_ok, spi_gnt, int_wr_blocked;
    logic [2:0]            err_set, err_d;

    assign cmd_op       = spi_data_in[DATA_WIDTH-1 -: 2];
    assign cmd_addr     = spi_data_in[ADDR_WIDTH-1:0];
    assign cmd_bad_addr = 32'(cmd_addr) >= DEPTH;

    // Grants are gated by rst so every output is 0 while reset is held.
    assign spi_req    = ~rst & ((state_q == RD_REQ) || (state_q == WR_REQ));
    assign int_req_ok = ~rst & int_req & ~int_rd_p1_q;
    assign spi_gnt    = spi_req & (~int_req_ok | ~rr_q);
    assign int_gnt    = int_req_ok & (~spi_req | rr_q);
    assign busy       = (state_q != IDLE);

`ifdef CSR_WR_PROTECT_EN
    assign int_wr_blocked = int_we && (int_addr == '0);
`else
    assign int_wr_blocked = 1'b0;
`endif

    always_comb begin
        csr_we    = 1'b0;
        csr_re    = 1'b0;
        csr_addr  = '0;
        csr_wdata = '0;
        if (spi_gnt) begin
            csr_addr = addr_q;
            if (state_q == WR_REQ) begin
                csr_we    = ~bad_addr_q;
                csr_wdata = wdata_q;
            end else begin
                csr_re = ~bad_addr_q;
            end
        end else if (int_gnt) begin
            csr_addr  = int_addr;
            csr_we    = int_we & ~int_wr_blocked;
            csr_re    = ~int_we;
            csr_wdata = int_we ? int_wdata : '0;
        end
    end

    always_comb begin
        err_set = 3'b000;
        if (state_q == IDLE && spi_data_rdy) begin
            err_set[0] = ((cmd_op == 2'b01) || (cmd_op == 2'b10)) && cmd_bad_addr;
            err_set[1] = (cmd_op == 2'b11);
        end
        if (int_gnt && int_wr_blocked)
            err_set[1] = 1'b1;
        if (spi_data_rdy && (state_q == RD_REQ || state_q == RD_DATA || state_q == WR_REQ))
            err_set[2] = 1'b1;
        if (state_q == WAIT_DATA && !spi_data_rdy && cnt_q == CNT_W'(TIMEOUT - 1))
            err_set[2] = 1'b1;
        err_d = (err_clr ? 3'b000 : err) | err_set;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            addr_q         <= '0;
            wdata_q        <= '0;
            bad_addr_q     <= 1'b0;
            cnt_q          <= '0;
            rr_q           <= 1'b0;
            int_rd_p1_q    <= 1'b0;
            spi_data_out   <= '0;
            spi_data_latch <= 1'b0;
            int_rdata      <= '0;
            int_rvalid     <= 1'b0;
            err            <= 3'b000;
        end else begin
            spi_data_latch <= 1'b0;
            int_rvalid     <= 1'b0;
            err            <= err_d;

            if (spi_gnt)
                rr_q <= 1'b1;
            else if (int_gnt)
                rr_q <= 1'b0;

            int_rd_p1_q <= int_gnt & ~int_we;
            if (int_rd_p1_q) begin
                int_rdata  <= csr_rdata;
                int_rvalid <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (spi_data_rdy) begin
                        addr_q     <= cmd_addr;
                        bad_addr_q <= cmd_bad_addr;
                        if (cmd_op == 2'b01) begin
                            state_q <= RD_REQ;
                        end else if (cmd_op == 2'b10) begin
                            cnt_q   <= '0;
                            state_q <= WAIT_DATA;
                        end
                    end
                end
                WAIT_DATA: begin
                    if (spi_data_rdy) begin
                        wdata_q <= spi_data_in;
                        state_q <= WR_REQ;
                    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RD_REQ: begin
                    if (spi_gnt)
                        state_q <= RD_DATA;
                end
                RD_DATA: begin
                    spi_data_out   <= bad_addr_q ? '0 : csr_rdata;
                    spi_data_latch <= 1'b1;
                    state_q        <= IDLE;
                end
                WR_REQ: begin
                    if (spi_gnt)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_csr_cmd_ctrl.sv
// Directed bench for csr_cmd_ctrl: RAM model, scoreboard queues checked by a negedge monitor.
module tb_csr_cmd_ctrl;
`ifdef CSR_WR_PROTECT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] spi_data_in = '0;
    logic       spi_data_rdy = 1'b0;
    logic [7:0] spi_data_out;
    logic       spi_data_latch;
    logic       int_req = 1'b0;
    logic       int_we = 1'b0;
    logic [5:0] int_addr = '0;
    logic [7:0] int_wdata = '0;
    logic       int_gnt;
    logic [7:0] int_rdata;
    logic       int_rvalid;
    logic       csr_we, csr_re;
    logic [5:0] csr_addr;
    logic [7:0] csr_wdata;
    logic [7:0] csr_rdata = '0;
    logic       busy;
    logic [2:0] err;
    logic       err_clr = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [23:0] exp_spi_q[$];  // {cycle, data}
    logic [23:0] exp_int_q[$];  // {cycle, data}
    logic [29:0] exp_wr_q[$];   // {cycle, addr, data}
    logic [21:0] exp_re_q[$];   // {cycle, addr}
    logic [15:0] exp_gnt_q[$];  // {cycle}

    csr_cmd_ctrl dut (
        .clk(clk), .rst(rst),
        .spi_data_in(spi_data_in), .spi_data_rdy(spi_data_rdy),
        .spi_data_out(spi_data_out), .spi_data_latch(spi_data_latch),
        .int_req(int_req), .int_we(int_we), .int_addr(int_addr), .int_wdata(int_wdata),
        .int_gnt(int_gnt), .int_rdata(int_rdata), .int_rvalid(int_rvalid),
        .csr_we(csr_we), .csr_re(csr_re), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
        .csr_rdata(csr_rdata), .busy(busy), .err(err), .err_clr(err_clr)
    );

    // ---------------- clock / cycle counter / RAM ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] mem [0:63];
    bit         mem_loaded = 1'b0;
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 64; i++) mem[i] <= 8'h00;
            mem[0] <= 8'h12;
            mem[3] <= 8'hC3;
            mem[4] <= 8'hA7;
            mem[6] <= 8'h66;
            mem[7] <= 8'h5E;
            mem_loaded <= 1'b1;
        end else begin
            if (csr_we) mem[csr_addr] <= csr_wdata;
            if (csr_re) csr_rdata <= mem[csr_addr];
        end
    end

    // ---------------- check helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_extra(input string name, input logic [31:0] val);
        n_checks++;
        n_fail++;
        $display("FAIL %s: unexpected event with value 0x%0h (cycle %0d)", name, val, cyc);
    endtask

    task automatic fail_missing(input string name, input logic [31:0] val);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event absent, expected value 0x%0h (cycle %0d)", name, val, cyc);
    endtask

    task automatic exp_spi(input int c, input logic [7:0] d); exp_spi_q.push_back({16'(c), d}); endtask
    task automatic exp_int(input int c, input logic [7:0] d); exp_int_q.push_back({16'(c), d}); endtask
    task automatic exp_wr(input int c, input logic [5:0] a, input logic [7:0] d); exp_wr_q.push_back({16'(c), a, d}); endtask
    task automatic exp_re(input int c, input logic [5:0] a); exp_re_q.push_back({16'(c), a}); endtask
    task automatic exp_gnt(input int c); exp_gnt_q.push_back(16'(c)); endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin : monitor
        logic [15:0] c16;
        logic [23:0] e24;
        logic [29:0] e30;
        logic [21:0] e22;
        logic [15:0] e16;
        c16 = 16'(cyc);
        if (!rst) begin
            if (csr_we && csr_re) fail_extra("csr_we_and_re", {csr_we, csr_re});
            if (spi_data_latch) begin
                if (exp_spi_q.size() == 0) fail_extra("spi_latch", spi_data_out);
                else begin
                    e24 = exp_spi_q.pop_front();
                    check("spi_latch_cycle", c16, e24[23:8]);
                    check("spi_data_out", spi_data_out, e24[7:0]);
                end
            end
            if (int_rvalid) begin
                if (exp_int_q.size() == 0) fail_extra("int_rvalid", int_rdata);
                else begin
                    e24 = exp_int_q.pop_front();
                    check("int_rvalid_cycle", c16, e24[23:8]);
                    check("int_rdata", int_rdata, e24[7:0]);
                end
            end
            if (csr_we) begin
                if (exp_wr_q.size() == 0) fail_extra("csr_we", {csr_addr, csr_wdata});
                else begin
                    e30 = exp_wr_q.pop_front();
                    check("csr_we_cycle", c16, e30[29:14]);
                    check("csr_we_addr", csr_addr, e30[13:8]);
                    check("csr_wdata", csr_wdata, e30[7:0]);
                end
            end
            if (csr_re) begin
                if (exp_re_q.size() == 0) fail_extra("csr_re", csr_addr);
                else begin
                    e22 = exp_re_q.pop_front();
                    check("csr_re_cycle", c16, e22[21:6]);
                    check("csr_re_addr", csr_addr, e22[5:0]);
                end
            end
            if (int_gnt) begin
                if (exp_gnt_q.size() == 0) fail_extra("int_gnt", int_addr);
                else begin
                    e16 = exp_gnt_q.pop_front();
                    check("int_gnt_cycle", c16, e16);
                end
            end
            if (exp_spi_q.size() != 0) begin
                e24 = exp_spi_q[0];
                if (e24[23:8] < c16) begin e24 = exp_spi_q.pop_front(); fail_missing("spi_latch_missing", e24[7:0]); end
            end
            if (exp_int_q.size() != 0) begin
                e24 = exp_int_q[0];
                if (e24[23:8] < c16) begin e24 = exp_int_q.pop_front(); fail_missing("int_rvalid_missing", e24[7:0]); end
            end
            if (exp_wr_q.size() != 0) begin
                e30 = exp_wr_q[0];
                if (e30[29:14] < c16) begin e30 = exp_wr_q.pop_front(); fail_missing("csr_we_missing", e30[13:0]); end
            end
            if (exp_re_q.size() != 0) begin
                e22 = exp_re_q[0];
                if (e22[21:6] < c16) begin e22 = exp_re_q.pop_front(); fail_missing("csr_re_missing", e22[5:0]); end
            end
            if (exp_gnt_q.size() != 0) begin
                e16 = exp_gnt_q[0];
                if (e16 < c16) begin e16 = exp_gnt_q.pop_front(); fail_missing("int_gnt_missing", e16); end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic gap(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic drive_byte(input logic [7:0] b, output int t);
        @(posedge clk); #1;
        t = cyc;
        spi_data_in  = b;
        spi_data_rdy = 1'b1;
        @(posedge clk); #1;
        spi_data_rdy = 1'b0;
    endtask

    task automatic clear_err();
        @(posedge clk); #1;
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        @(negedge clk);
        check("err_after_clr", err, 3'b000);
    endtask

    // Caller aligns to posedge+1 before calling; grant expected 'delay' cycles later.
    task automatic int_access(input logic we, input logic [5:0] addr, input logic [7:0] wd,
                              input logic [7:0] rd_exp, input int delay, input logic we_exp);
        int t;
        bit got;
        t = cyc;
        int_req   = 1'b1;
        int_we    = we;
        int_addr  = addr;
        int_wdata = wd;
        exp_gnt(t + delay);
        if (we) begin
            if (we_exp) exp_wr(t + delay, addr, wd);
        end else begin
            exp_re(t + delay, addr);
            exp_int(t + delay + 2, rd_exp);
        end
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            got = int_gnt;
        end
        if (!got) fail_missing("int_gnt_timeout", addr);
        @(posedge clk); #1;
        int_req   = 1'b0;
        int_we    = 1'b0;
        int_addr  = '0;
        int_wdata = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_spi_data_out"}, spi_data_out, 8'h00);
        check({tag, "_spi_data_latch"}, spi_data_latch, 1'b0);
        check({tag, "_int_gnt"}, int_gnt, 1'b0);
        check({tag, "_int_rdata"}, int_rdata, 8'h00);
        check({tag, "_int_rvalid"}, int_rvalid, 1'b0);
        check({tag, "_csr_we"}, csr_we, 1'b0);
        check({tag, "_csr_re"}, csr_re, 1'b0);
        check({tag, "_csr_addr"}, csr_addr, 6'd0);
        check({tag, "_csr_wdata"}, csr_wdata, 8'h00);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_err"}, err, 3'b000);
    endtask

    task automatic report();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    endtask

    initial begin : watchdog
        #200000;
        fail_missing("watchdog_timeout", 0);
        report();
        $finish;
    end

    // ---------------- main sequence ----------------
    initial begin : main
        int t, t1;
        // Reset with an internal request held: no grant may leak out.
        int_req  = 1'b1;
        int_addr = 6'd7;
        #12;
        check_reset_outputs("reset");
        int_req  = 1'b0;
        int_addr = '0;
        @(negedge clk);
        rst = 1'b0;
        gap(2);

        // SPI write 0x3C to address 5
        drive_byte(8'h85, t);
        check("busy_wait_data", busy, 1'b1);
        drive_byte(8'h3C, t1);
        exp_wr(t1 + 1, 6'd5, 8'h3C);
        gap(2);
        @(negedge clk);
        check("busy_after_write", busy, 1'b0);

        // SPI read of address 4
        drive_byte(8'h44, t);
        exp_re(t + 1, 6'd4);
        exp_spi(t + 3, 8'hA7);
        gap(4);

        // Read back address 5
        drive_byte(8'h45, t);
        exp_re(t + 1, 6'd5);
        exp_spi(t + 3, 8'h3C);
        gap(4);

        // Internal write then internal read of address 10
        @(posedge clk); #1;
        int_access(1'b1, 6'd10, 8'h99, 8'h00, 0, 1'b1);
        gap(2);
        @(posedge clk); #1;
        int_access(1'b0, 6'd10, 8'h00, 8'h99, 0, 1'b1);
        gap(3);

        // Contention: SPI read of 3 and internal read of 7 in the same cycle, SPI favoured
        @(posedge clk); #1;
        t = cyc;
        spi_data_in  = 8'h43;
        spi_data_rdy = 1'b1;
        exp_re(t + 1, 6'd3);
        exp_spi(t + 3, 8'hC3);
        @(posedge clk); #1;
        spi_data_rdy = 1'b0;
        int_access(1'b0, 6'd7, 8'h00, 8'h5E, 1, 1'b1);
        gap(4);

        // Illegal op
        drive_byte(8'hC0, t);
        @(negedge clk);
        check("err_bad_op", err, 3'b010);
        check("busy_bad_op", busy, 1'b0);
        clear_err();

        // Out-of-range read returns 0x00 with a latch pulse
        drive_byte(8'h7F, t);
        exp_spi(t + 3, 8'h00);
        gap(3);
        @(negedge clk);
        check("err_bad_addr_rd", err, 3'b001);

        // err_clr together with a new error: the new error survives
        @(posedge clk); #1;
        spi_data_in  = 8'hC0;
        spi_data_rdy = 1'b1;
        err_clr      = 1'b1;
        @(posedge clk); #1;
        spi_data_rdy = 1'b0;
        err_clr      = 1'b0;
        @(negedge clk);
        check("err_clr_vs_new", err, 3'b010);
        clear_err();

        // Out-of-range write consumes its data byte, no csr_we
        drive_byte(8'hA0, t);
        drive_byte(8'h11, t);
        gap(2);
        @(negedge clk);
        check("err_bad_addr_wr", err, 3'b001);
        check("busy_bad_addr_wr", busy, 1'b0);
        clear_err();

        // Overrun: byte arrives while the read is still requesting
        @(posedge clk); #1;
        t = cyc;
        spi_data_in  = 8'h44;
        spi_data_rdy = 1'b1;
        exp_re(t + 1, 6'd4);
        exp_spi(t + 3, 8'hA7);
        @(posedge clk); #1;
        spi_data_in = 8'h00;
        @(posedge clk); #1;
        spi_data_rdy = 1'b0;
        gap(3);
        @(negedge clk);
        check("err_overrun", err, 3'b100);
        clear_err();

        // Write command with no data byte: times out 255 edges after the command edge
        drive_byte(8'h81, t);
        while (cyc < t + 255) @(negedge clk);
        check("busy_before_timeout", busy, 1'b1);
        check("err_before_timeout", err, 3'b000);
        @(negedge clk);
        check("err_timeout", err, 3'b100);
        check("busy_after_timeout", busy, 1'b0);
        clear_err();

        // Internal write of 0xFF to the control register
        @(posedge clk); #1;
        int_access(1'b1, 6'd0, 8'hFF, 8'h00, 0, !PROT);
        @(negedge clk);
        check("err_int_wr_ctrl", err, PROT ? 3'b010 : 3'b000);
        clear_err();
        gap(2);

        // Reset asserted while the write sits in WR_REQ
        drive_byte(8'h86, t);
        @(posedge clk); #1;
        spi_data_in  = 8'h77;
        spi_data_rdy = 1'b1;
        @(posedge clk); #1;
        rst          = 1'b1;
        spi_data_rdy = 1'b0;
        #1;
        check_reset_outputs("midop_reset");
        @(negedge clk);
        rst = 1'b0;
        gap(2);

        // Address 6 keeps its old contents
        drive_byte(8'h46, t);
        exp_re(t + 1, 6'd6);
        exp_spi(t + 3, 8'h66);
        gap(4);

        // Control register reflects whether the internal write was blocked
        drive_byte(8'h40, t);
        exp_re(t + 1, 6'd0);
        exp_spi(t + 3, PROT ? 8'h12 : 8'hFF);
        gap(4);

        check("spi_queue_drained", exp_spi_q.size(), 0);
        check("int_queue_drained", exp_int_q.size(), 0);
        check("wr_queue_drained", exp_wr_q.size(), 0);
        check("re_queue_drained", exp_re_q.size(), 0);
        check("gnt_queue_drained", exp_gnt_q.size(), 0);
        report();
        $finish;
    end
endmodule

// File: doc/csr_cmd_ctrl.md
Name: csr_cmd_ctrl

Overview:
Command sequencer and access arbiter for the CSR register file. It parses bytes from the SPI block into read/write commands and drives the single CSR RAM port. It shares that port with one internal requester (PWM/GPIO reload logic) using round-robin arbitration. Sits between the SPI byte interface, the CSR RAM and the peripheral logic.

Parameters:
ADDR_WIDTH, 6, width of the CSR address field
DATA_WIDTH, 8, CSR word and SPI byte width
DEPTH, 32, number of implemented CSR words; legal addresses are 0..DEPTH-1
TIMEOUT, 255, max cycles allowed between a write command byte and its data byte

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
spi_data_in  in  DATA_WIDTH  received SPI byte
spi_data_rdy  in  1  one-cycle pulse, spi_data_in valid
spi_data_out  out  DATA_WIDTH  byte to transmit
spi_data_latch  out  1  one-cycle pulse, spi_data_out valid
int_req  in  1  internal access request, held until int_gnt
int_we  in  1  1=write, 0=read
int_addr  in  ADDR_WIDTH  internal address
int_wdata  in  DATA_WIDTH  internal write data
int_gnt  out  1  combinational grant, one cycle per access
int_rdata  out  DATA_WIDTH  internal read data
int_rvalid  out  1  one-cycle pulse, int_rdata valid
csr_we  out  1  RAM write enable
csr_re  out  1  RAM read enable
csr_addr  out  ADDR_WIDTH  RAM address
csr_wdata  out  DATA_WIDTH  RAM write data
csr_rdata  in  DATA_WIDTH  RAM read data, valid the cycle after csr_re
busy  out  1  FSM not in IDLE
err  out  3  sticky: [0] bad address, [1] bad op, [2] overrun/timeout
err_clr  in  1  clears err; a new error in the same cycle wins

Behaviour:
- Reset values: all outputs 0; FSM IDLE; round-robin pointer favours SPI; timeout counter 0.
- Command byte format: op = spi_data_in[7:6], addr = spi_data_in[ADDR_WIDTH-1:0].
- Op codes: 00 NOP; 01 read; 10 write; 11 illegal (sets err[1], stays IDLE).
- FSM states: IDLE, WAIT_DATA, RD_REQ, RD_DATA, WR_REQ.
- IDLE + rdy, op=01 -> RD_REQ.
- IDLE + rdy, op=10 -> WAIT_DATA; timeout counter cleared.
- WAIT_DATA + rdy -> latch data byte, go to WR_REQ.
- WAIT_DATA without rdy -> counter increments; reaching TIMEOUT sets err[2] and returns to IDLE.
- RD_REQ / WR_REQ: assert the SPI request; remain in the state until granted.
- RD_REQ granted -> csr_re=1 that cycle -> RD_DATA.
- RD_DATA: next edge registers spi_data_out <= csr_rdata and pulses spi_data_latch -> IDLE.
- WR_REQ granted -> csr_we=1, csr_wdata = latched byte -> IDLE.
- Read latency: spi_data_latch rises 2 edges after the command-sampling edge when uncontended; each lost arbitration adds one cycle.
- Address >= DEPTH: sets err[0]. A read returns 0x00 with spi_data_latch still pulsed. A write consumes its data byte and issues no csr_we.
- spi_data_rdy in RD_REQ, RD_DATA or WR_REQ: byte dropped, err[2] set, FSM unaffected.
- Arbitration: one access per cycle.
  - Lone requester is granted immediately.
  - Simultaneous requests go to the side not granted last; the pointer updates on every grant.
  - Neither side waits more than one cycle.
- Internal access: on int_gnt, csr_addr/we/wdata come from int_*.
  - An internal read pulses int_rvalid with int_rdata registered from csr_rdata 2 edges after the grant edge.
  - int_req is ignored while an internal read is in flight (no back-to-back internal reads).
- csr_we, csr_re and int_gnt are never high for both sources in the same cycle.
- Reset mid-operation: async return to IDLE; pending command discarded, no partial write.

Optional Feature:
CSR_WR_PROTECT_EN: when defined, internal writes to address 0 (control register) are blocked.
- int_gnt still pulses; csr_we stays 0; err[1] is set.
- SPI writes to address 0 are unaffected.
- Without the macro, internal writes to address 0 proceed normally.

Test Plan:
- Write: rdy 0x85 then rdy 0x3C -> csr_we=1, csr_addr=5, csr_wdata=0x3C for one cycle; busy=0 after.
- Read: RAM[4]=0xA7; rdy 0x44 -> csr_re at edge+1, spi_data_out=0xA7 with spi_data_latch at edge+2.
- Contention: SPI read to 3 and int_req read of 7 in the same cycle, pointer favouring SPI -> SPI granted first, internal next cycle; int_rvalid with RAM[7]; SPI latch delayed 0 cycles, internal 1 cycle.
- Errors: rdy 0xC0 -> err=3'b010. rdy 0x7F (addr 63) -> err[0], spi_data_out=0x00. rdy 0x81 then no byte for 255 cycles -> err[2], IDLE. err_clr -> err=0.
- Reset: rst asserted in WR_REQ after data byte -> no csr_we; all outputs 0 asynchronously.
- Macro on: internal write 0xFF to addr 0 -> int_gnt=1, csr_we=0, err[1]=1. Macro off: csr_we=1.
